c_mutex_split4: RTL and testbench
=================================

Name: c_mutex_split4

Overview:
- Clocked 4-way demultiplexer for the drive/free handshake; the counterpart of the 4-input mutex merge.
- Takes one upstream drive/data/select transaction and steers it to exactly one of four downstream channels.
- Waits for that channel's free, then returns free upstream.
- Sits at the fan-out point of a shared pipeline stage where the merge sits at the fan-in.

Parameters:
DATA_WIDTH, 32, width of the data word
DRIVE_LAT, 1, cycles from the accepting edge to the o_driveN pulse (1..15)
FREE_LAT, 1, cycles from the accepting free edge to the o_free pulse (1..15)
TIMEOUT_CYCLES, 1024, free-wait limit when the optional feature is compiled in (2..65535)

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous assert, active-low
i_drive  in  1  upstream drive; one-cycle pulse
i_sel  in  2  destination channel, sampled with i_drive
i_data  in  DATA_WIDTH  upstream data, sampled with i_drive
o_free  out  1  upstream free; one-cycle pulse
o_drive0..o_drive3  out  1 each  downstream drive pulses
o_data  out  DATA_WIDTH  captured data; shared by all channels
i_free0..i_free3  in  1 each  downstream free pulses
o_busy  out  1  high whenever state != IDLE
o_err  out  1  sticky protocol-violation flag
o_timeout  out  1  sticky timeout flag; tied 0 when the feature is absent

Behaviour:
- Reset (rstn=0), asynchronous: state=IDLE, counter=0, sel register=0.
- Reset values: o_data=0, all o_drive*=0, o_free=0, o_busy=0, o_err=0, o_timeout=0.
- Reset mid-transaction drops the pending transaction; no free is generated.
- All outputs are registered. E0 denotes the edge that samples i_drive=1 in IDLE.
- IDLE:
  - i_drive=1 -> capture i_data into o_data and i_sel into sel, load counter=DRIVE_LAT-1.
  - Go to DRIVE_DLY, or straight to WAIT_FREE when DRIVE_LAT=1.
  - The drive pulse is o_drive[sel] high for exactly one cycle, from edge E0+DRIVE_LAT-1 to edge E0+DRIVE_LAT.
  - With DRIVE_LAT=1, o_drive[sel] is high in the cycle right after E0.
- DRIVE_DLY: decrement the counter. At 0, assert o_drive[sel] and go to WAIT_FREE.
- WAIT_FREE:
  - Accepts only i_free[sel], sampled from the edge that ends the drive pulse onward.
  - The accepting edge F loads counter=FREE_LAT-1 and goes to FREE_DLY.
  - o_free is high for exactly one cycle, from edge F+FREE_LAT-1 to edge F+FREE_LAT.
- FREE_DLY: decrement the counter; at the edge ending the o_free pulse, go to IDLE.
- The next i_drive is accepted at edge F+FREE_LAT+1 or later.
- o_data holds its value from capture until the next accepted drive. It never changes while busy.
- Violations set o_err=1. o_err stays set until reset. In every case the state machine continues as if the violation had not occurred:
  - i_drive=1 sampled in any state other than IDLE, including the edge ending the o_free pulse -> drive ignored, data/sel not recaptured.
  - i_free* for an unselected channel sampled in WAIT_FREE -> ignored.
  - Any i_free* sampled outside WAIT_FREE -> ignored.
  - Selected and unselected frees on the same edge -> selected accepted, o_err set.
- Only one o_drive* is ever high at a time. o_drive* and o_free are never high in the same cycle.

Optional Feature:
- Macro: C_MUTEX_SPLIT4_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on WAIT_FREE entry and increments each cycle in WAIT_FREE.
  - When it reaches TIMEOUT_CYCLES with no selected free, the block acts as if i_free[sel] had been sampled on that edge: normal FREE_LAT path, o_free pulse.
  - It also sets sticky o_timeout=1.
- Undefined: no counter is built; WAIT_FREE waits indefinitely; o_timeout is constant 0.

Test Plan:
- Defaults; i_drive=1, i_sel=2, i_data=0xA5A5_0001 at edge E0 -> o_data=0xA5A5_0001 after E0; o_drive2 high one cycle after E0; o_busy=1; o_drive0/1/3 stay 0.
- Continue: i_free2 pulse at edge F -> o_free high in cycle after F; o_busy=0 after F+1; new drive to sel=0 at F+2 -> o_drive0 pulse.
- DRIVE_LAT=3, FREE_LAT=2; sel=3 -> o_drive3 high between E0+2 and E0+3; i_free3 at F -> o_free between F+1 and F+2.
- In WAIT_FREE for sel=1, pulse i_free0 then i_drive (data 0x1234) -> both ignored, o_err=1, o_data unchanged, still waiting; then i_free1 completes normally.
- Assert rstn=0 mid-WAIT_FREE -> all outputs 0 immediately; after release no o_free is generated; the next drive works.
- With C_MUTEX_SPLIT4_TIMEOUT_EN and TIMEOUT_CYCLES=8, no free -> o_free pulse after the timeout via the FREE_LAT path, o_timeout=1. Without the macro, the block stays busy for 1000 cycles.

Source files
------------

// File: rtl/c_mutex_split4.sv
// Clocked 4-way drive/free demultiplexer: steers one upstream transaction to a selected
// downstream channel and returns free upstream. Optional free-wait timeout: C_MUTEX_SPLIT4_TIMEOUT_EN.
module c_mutex_split4 #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DRIVE_LAT      = 1,
  parameter int unsigned FREE_LAT       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_drive,
  input  logic [1:0]            i_sel,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_free,
  output logic                  o_drive0,
  output logic                  o_drive1,
  output logic                  o_drive2,
  output logic                  o_drive3,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_free0,
  input  logic                  i_free1,
  input  logic                  i_free2,
  input  logic                  i_free3,
  output logic                  o_busy,
  output logic                  o_err,
  output logic                  o_timeout
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_W  = 16;
  localparam int unsigned NCH   = 4;
  localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

  // Elaboration-time range checks on the latency and timeout parameters
  if (DRIVE_LAT < 1 || DRIVE_LAT > 15) begin : g_bad_drive_lat
    $error("c_mutex_split4: DRIVE_LAT must be 1..15");
  end
  if (FREE_LAT < 1 || FREE_LAT > 15) begin : g_bad_free_lat
    $error("c_mutex_split4: FREE_LAT must be 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("c_mutex_split4: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE_DLY,
    S_WAIT_FREE,
    S_FREE_DLY
  } state_t;

  state_t                r_state, w_state;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [1:0]            r_sel, w_sel;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic [NCH-1:0]        r_drive, w_drive;
  logic                  r_free, w_free;
  logic                  r_busy, w_busy;
  logic                  r_err, w_err;
  logic [NCH-1:0]        w_free_vec;
  logic                  w_sel_free;
  logic                  w_other_free;
  logic                  w_accept;

`ifdef C_MUTEX_SPLIT4_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] r_wait_cnt, w_wait_cnt;
  logic            r_timeout, w_timeout;
`endif

  assign w_free_vec   = {i_free3, i_free2, i_free1, i_free0};
  assign w_sel_free   = w_free_vec[r_sel];
  assign w_other_free = |(w_free_vec & ~(ONE_HOT0 << r_sel));

  // Next-state, datapath and output computation
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_sel    = r_sel;
    w_data   = r_data;
    w_drive  = '0;
    w_free   = 1'b0;
    w_err    = r_err;
    w_accept = 1'b0;
`ifdef C_MUTEX_SPLIT4_TIMEOUT_EN
    w_wait_cnt = r_wait_cnt;
    w_timeout  = r_timeout;
`endif

    // Protocol violations are flagged but never alter the sequencing
    if (i_drive && (r_state != S_IDLE))                  w_err = 1'b1;
    if ((|w_free_vec) && (r_state != S_WAIT_FREE))       w_err = 1'b1;
    if ((r_state == S_WAIT_FREE) && w_other_free)        w_err = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (i_drive) begin
          w_data = i_data;
          w_sel  = i_sel;
          w_cnt  = CNT_W'(DRIVE_LAT - 1);
          if (DRIVE_LAT == 1) begin
            w_drive = ONE_HOT0 << i_sel;
            w_state = S_WAIT_FREE;
`ifdef C_MUTEX_SPLIT4_TIMEOUT_EN
            w_wait_cnt = '0;
`endif
          end else begin
            w_state = S_DRIVE_DLY;
          end
        end
      end

      S_DRIVE_DLY: begin
        // Pulse is raised on the edge that takes the counter to zero
        if (r_cnt == CNT_W'(1)) begin
          w_cnt   = '0;
          w_drive = ONE_HOT0 << r_sel;
          w_state = S_WAIT_FREE;
`ifdef C_MUTEX_SPLIT4_TIMEOUT_EN
          w_wait_cnt = '0;
`endif
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end

      S_WAIT_FREE: begin
        w_accept = w_sel_free;
`ifdef C_MUTEX_SPLIT4_TIMEOUT_EN
        if (!w_sel_free) begin
          if ((r_wait_cnt + TO_W'(1)) == TO_LIMIT) begin
            w_accept  = 1'b1;
            w_timeout = 1'b1;
          end else begin
            w_wait_cnt = r_wait_cnt + TO_W'(1);
          end
        end
`endif
        if (w_accept) begin
          w_cnt   = CNT_W'(FREE_LAT - 1);
          w_state = S_FREE_DLY;
          if (FREE_LAT == 1) w_free = 1'b1;
        end
      end

      S_FREE_DLY: begin
        if (r_free) begin
          w_state = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_cnt  = '0;
          w_free = 1'b1;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end

      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_drive <= '0;
      r_free  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sel   <= w_sel;
      r_data  <= w_data;
      r_drive <= w_drive;
      r_free  <= w_free;
      r_busy  <= w_busy;
      r_err   <= w_err;
    end
  end

`ifdef C_MUTEX_SPLIT4_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt;
      r_timeout  <= w_timeout;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_drive0 = r_drive[0];
  assign o_drive1 = r_drive[1];
  assign o_drive2 = r_drive[2];
  assign o_drive3 = r_drive[3];
  assign o_free   = r_free;
  assign o_data   = r_data;
  assign o_busy   = r_busy;
  assign o_err    = r_err;

endmodule

// File: tb/tb_c_mutex_split4.sv
// Directed bench for c_mutex_split4: one instance at default latencies, one at
// DRIVE_LAT=3/FREE_LAT=2; both use TIMEOUT_CYCLES=8.
module tb_c_mutex_split4;

  logic clk;
  logic rstn;

  logic        a_drive, b_drive;
  logic [1:0]  a_sel, b_sel;
  logic [31:0] a_din, b_din;
  logic [3:0]  a_fr, b_fr;
  logic        a_ofree, b_ofree;
  logic [3:0]  a_drv, b_drv;
  logic [31:0] a_dout, b_dout;
  logic        a_busy, b_busy, a_err, b_err, a_to, b_to;

  int n_cmp = 0;
  int n_mis = 0;

  c_mutex_split4 #(.DATA_WIDTH(32), .DRIVE_LAT(1), .FREE_LAT(1), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .rstn(rstn), .i_drive(a_drive), .i_sel(a_sel), .i_data(a_din),
    .o_free(a_ofree), .o_drive0(a_drv[0]), .o_drive1(a_drv[1]), .o_drive2(a_drv[2]),
    .o_drive3(a_drv[3]), .o_data(a_dout), .i_free0(a_fr[0]), .i_free1(a_fr[1]),
    .i_free2(a_fr[2]), .i_free3(a_fr[3]), .o_busy(a_busy), .o_err(a_err), .o_timeout(a_to)
  );

  c_mutex_split4 #(.DATA_WIDTH(32), .DRIVE_LAT(3), .FREE_LAT(2), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rstn(rstn), .i_drive(b_drive), .i_sel(b_sel), .i_data(b_din),
    .o_free(b_ofree), .o_drive0(b_drv[0]), .o_drive1(b_drv[1]), .o_drive2(b_drv[2]),
    .o_drive3(b_drv[3]), .o_data(b_dout), .i_free0(b_fr[0]), .i_free1(b_fr[1]),
    .i_free2(b_fr[2]), .i_free3(b_fr[3]), .o_busy(b_busy), .o_err(b_err), .o_timeout(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    rstn = 1'b0;
    a_drive = 1'b0; a_sel = 2'd0; a_din = '0; a_fr = '0;
    b_drive = 1'b0; b_sel = 2'd0; b_din = '0; b_fr = '0;
    repeat (2) tick();

    // Reset state
    check("rst_a_data", a_dout, 32'h0);
    check("rst_a_drv", 32'(a_drv), 32'h0);
    check("rst_a_free", 32'(a_ofree), 32'h0);
    check("rst_a_busy", 32'(a_busy), 32'h0);
    check("rst_a_err", 32'(a_err), 32'h0);
    check("rst_a_to", 32'(a_to), 32'h0);
    check("rst_b_busy", 32'(b_busy), 32'h0);
    check("rst_b_data", b_dout, 32'h0);
    rstn = 1'b1;
    tick();

    // Basic transaction to channel 2, then channel 0 at F+2
    a_drive = 1'b1; a_sel = 2'd2; a_din = 32'hA5A5_0001;
    tick();
    a_drive = 1'b0;
    check("t1_data", a_dout, 32'hA5A5_0001);
    check("t1_drv2", 32'(a_drv), 32'h4);
    check("t1_busy", 32'(a_busy), 32'h1);
    check("t1_nofree", 32'(a_ofree), 32'h0);
    tick();
    check("t1_drv_end", 32'(a_drv), 32'h0);
    check("t1_busy_wait", 32'(a_busy), 32'h1);
    a_fr = 4'b0100;
    tick();
    a_fr = '0;
    check("t1_free", 32'(a_ofree), 32'h1);
    check("t1_free_nodrv", 32'(a_drv), 32'h0);
    tick();
    check("t1_free_end", 32'(a_ofree), 32'h0);
    check("t1_idle", 32'(a_busy), 32'h0);
    a_drive = 1'b1; a_sel = 2'd0; a_din = 32'h0000_00C3;
    tick();
    a_drive = 1'b0;
    check("t1b_drv0", 32'(a_drv), 32'h1);
    check("t1b_data", a_dout, 32'h0000_00C3);
    tick();
    a_fr = 4'b0001;
    tick();
    a_fr = '0;
    check("t1b_free", 32'(a_ofree), 32'h1);
    tick();
    check("t1b_idle", 32'(a_busy), 32'h0);
    check("t1b_noerr", 32'(a_err), 32'h0);

    // Wrong-channel free and drive while busy: ignored, error flagged
    a_drive = 1'b1; a_sel = 2'd1; a_din = 32'hDEAD_0011;
    tick();
    a_drive = 1'b0;
    check("t2_drv1", 32'(a_drv), 32'h2);
    tick();
    a_fr = 4'b0001;
    tick();
    a_fr = '0;
    check("t2_err", 32'(a_err), 32'h1);
    check("t2_nofree", 32'(a_ofree), 32'h0);
    check("t2_busy", 32'(a_busy), 32'h1);
    a_drive = 1'b1; a_sel = 2'd3; a_din = 32'h0000_1234;
    tick();
    a_drive = 1'b0;
    check("t2_data_hold", a_dout, 32'hDEAD_0011);
    check("t2_no_drv", 32'(a_drv), 32'h0);
    check("t2_still_busy", 32'(a_busy), 32'h1);
    a_fr = 4'b0010;
    tick();
    a_fr = '0;
    check("t2_free", 32'(a_ofree), 32'h1);
    tick();
    check("t2_idle", 32'(a_busy), 32'h0);

    // Asynchronous reset in the middle of WAIT_FREE
    a_drive = 1'b1; a_sel = 2'd3; a_din = 32'h5555_AAAA;
    tick();
    a_drive = 1'b0;
    tick();
    #1 rstn = 1'b0;
    #1;
    check("t3_rst_data", a_dout, 32'h0);
    check("t3_rst_busy", 32'(a_busy), 32'h0);
    check("t3_rst_err", 32'(a_err), 32'h0);
    check("t3_rst_drv", 32'(a_drv), 32'h0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_no_free", 32'(a_ofree), 32'h0);
    end
    check("t3_idle", 32'(a_busy), 32'h0);
    a_drive = 1'b1; a_sel = 2'd1; a_din = 32'h0000_0077;
    tick();
    a_drive = 1'b0;
    check("t3_drv1", 32'(a_drv), 32'h2);
    check("t3_data", a_dout, 32'h0000_0077);
    tick();
    a_fr = 4'b0010;
    tick();
    a_fr = '0;
    check("t3_free", 32'(a_ofree), 32'h1);
    tick();
    check("t3_done", 32'(a_busy), 32'h0);

    // DRIVE_LAT=3, FREE_LAT=2 on channel 3
    b_drive = 1'b1; b_sel = 2'd3; b_din = 32'h0BAD_F00D;
    tick();
    b_drive = 1'b0;
    check("t4_e0_drv", 32'(b_drv), 32'h0);
    check("t4_busy", 32'(b_busy), 32'h1);
    check("t4_data", b_dout, 32'h0BAD_F00D);
    tick();
    check("t4_e1_drv", 32'(b_drv), 32'h0);
    tick();
    check("t4_e2_drv3", 32'(b_drv), 32'h8);
    tick();
    check("t4_e3_drv", 32'(b_drv), 32'h0);
    b_fr = 4'b1000;
    tick();
    b_fr = '0;
    check("t4_f0_free", 32'(b_ofree), 32'h0);
    check("t4_f0_busy", 32'(b_busy), 32'h1);
    tick();
    check("t4_f1_free", 32'(b_ofree), 32'h1);
    tick();
    check("t4_f2_free", 32'(b_ofree), 32'h0);
    check("t4_f2_idle", 32'(b_busy), 32'h0);
    check("t4_noerr", 32'(b_err), 32'h0);

    // Selected plus unselected free together; drive on the edge ending o_free
    b_drive = 1'b1; b_sel = 2'd0; b_din = 32'h0000_0011;
    tick();
    b_drive = 1'b0;
    repeat (3) tick();
    b_fr = 4'b0101;
    tick();
    b_fr = '0;
    check("t5_err", 32'(b_err), 32'h1);
    check("t5_busy", 32'(b_busy), 32'h1);
    tick();
    check("t5_free", 32'(b_ofree), 32'h1);
    b_drive = 1'b1; b_sel = 2'd2; b_din = 32'h0000_0099;
    tick();
    b_drive = 1'b0;
    check("t5_late_drive_idle", 32'(b_busy), 32'h0);
    check("t5_late_drive_data", b_dout, 32'h0000_0011);
    b_drive = 1'b1;
    tick();
    b_drive = 1'b0;
    check("t5_next_busy", 32'(b_busy), 32'h1);
    check("t5_next_data", b_dout, 32'h0000_0099);
    repeat (2) tick();
    check("t5_next_drv2", 32'(b_drv), 32'h4);
    tick();
    b_fr = 4'b0100;
    tick();
    b_fr = '0;
    repeat (2) tick();
    check("t5_next_idle", 32'(b_busy), 32'h0);

    // Free-wait timeout behaviour
    a_drive = 1'b1; a_sel = 2'd2; a_din = 32'h0000_0042;
    tick();
    a_drive = 1'b0;
`ifdef C_MUTEX_SPLIT4_TIMEOUT_EN
    repeat (7) tick();
    check("t6_pre_free", 32'(a_ofree), 32'h0);
    check("t6_pre_to", 32'(a_to), 32'h0);
    tick();
    check("t6_to_free", 32'(a_ofree), 32'h1);
    check("t6_to_flag", 32'(a_to), 32'h1);
    tick();
    check("t6_to_idle", 32'(a_busy), 32'h0);
`else
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (a_ofree) pulses++;
    end
    check("t6_no_free", 32'(pulses), 32'h0);
    check("t6_still_busy", 32'(a_busy), 32'h1);
    check("t6_to_zero", 32'(a_to), 32'h0);
    a_fr = 4'b0100;
    tick();
    a_fr = '0;
    check("t6_late_free", 32'(a_ofree), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
